// File: rtl/alu_seq_n.sv
// alu_seq_n -- clocked, parametrised ALU with start/done handshake.
//
// Latches A, B and op when start is seen while not busy, and delivers a
// registered 2W-bit result in ALUout with a one-cycle done pulse.
// Single-cycle ops complete at the accept edge. MUL optionally runs as a
// W-cycle shift-add multiplier.
//
// Configuration macro: ALU_SEQ_MUL_EN
//   defined   : op 010 is a multi-cycle unsigned multiply (IDLE/MUL FSM)
//   undefined : op 010 completes in one cycle with ALUout = 0, busy tied 0
//
// Ports:
//   clk     in   1    system clock, rising edge
//   resetn  in   1    synchronous reset, active-low
//   start   in   1    request, accepted only while busy == 0
//   op      in   3    operation select, sampled on accept
//   A       in   W    operand A, sampled on accept
//   B       in   W    operand B, sampled on accept
//   ALUout  out  2W   registered result, held until next completion
//   busy    out  1    high while the multiplier iterates
//   done    out  1    one-cycle pulse after ALUout is updated

module alu_seq_n #(
    parameter int unsigned W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    output logic [2*W-1:0]   ALUout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned RW = 2 * W;

    logic [RW-1:0] r_alu;
    logic          r_done;
    logic [RW-1:0] w_single;
    logic          w_accept;

    assign ALUout = r_alu;
    assign done   = r_done;

    // Result of every single-cycle op, computed from the live inputs so it
    // can be registered directly at the accept edge.
    always_comb begin
        w_single = '0;
        case (op)
            3'b000: w_single = RW'(A) + RW'(B);
            3'b001: w_single = r_alu + RW'(A);
            3'b010: w_single = '0;
            3'b011: w_single = {A | B, A ^ B};
            3'b100: w_single = RW'(|{A, B});
            3'b101: w_single = RW'(&{A, B});
            3'b110: w_single = {A, B};
            // Shift amounts >= RW drop every bit, giving 0 naturally.
            3'b111: w_single = RW'(A) << B;
            default: w_single = '0;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN

    localparam int unsigned CW = $clog2(W);

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [RW-1:0] r_partial;
    logic [RW-1:0] r_mcand;
    logic [W-1:0]  r_mplier;
    logic [CW-1:0] r_cnt;
    logic [RW-1:0] w_partial_add;
    logic          w_last;

    assign busy          = (r_state == S_MUL);
    assign w_accept      = start && !busy;
    assign w_last        = busy && (r_cnt == CW'(W - 1));
    assign w_partial_add = r_partial + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && op == 3'b010) w_state_nxt = S_MUL;
            S_MUL:   if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_alu     <= '0;
            r_done    <= 1'b0;
            r_partial <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                if (op == 3'b010) begin
                    r_partial <= '0;
                    r_mcand   <= RW'(A);
                    r_mplier  <= B;
                    r_cnt     <= '0;
                end else begin
                    r_alu  <= w_single;
                    r_done <= 1'b1;
                end
            end
            if (busy) begin
                r_partial <= w_partial_add;
                r_mcand   <= r_mcand << 1;
                r_mplier  <= r_mplier >> 1;
                r_cnt     <= r_cnt + CW'(1);
                // Commit on the last iteration using the in-flight sum so
                // ALUout only ever shows the finished product.
                if (w_last) begin
                    r_alu  <= w_partial_add;
                    r_done <= 1'b1;
                end
            end
        end
    end

`else

    assign busy     = 1'b0;
    assign w_accept = start;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_alu  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_alu  <= w_single;
                r_done <= 1'b1;
            end
        end
    end

`endif

endmodule
